ctrl_sequencer: RTL and testbench

- Multi-cycle control unit sitting directly upstream of the ALU/accumulator stage; generates alu_op, Wen, INC and the bus/register/memory strobes that feed it.
- Runs a fetch–decode–execute loop over one-byte instructions held in the external IR; the datapath (IR, PC, AR, register file, memory, AC) is external.
- Moore FSM: all outputs are decoded from the current state and the IR contents, never from same-cycle datapath results except z_flag in EXEC.

---
 rtl/ctrl_sequencer_if.sv | 39 +++
 rtl/ctrl_sequencer.sv | 171 +++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the instruction sequencer and the ALU/accumulator datapath.
// Latency: none; wires only, the sequencer registers every strobe except pc_load.
// Backpressure: none; the datapath consumes strobes unconditionally.
interface ctrl_sequencer_if #(
   parameter int NREG = 8
);
   logic            start;
   logic [7:0]      instr;
   logic            z_flag;
   logic [2:0]      alu_op;
   logic            Wen;
   logic            INC;
   logic            ac_clr;
   logic [3:0]      bus_sel;
   logic [NREG-1:0] reg_wen;
   logic            ir_wen;
   logic            pc_inc;
   logic            pc_load;
   logic            ar_wen;
   logic            addr_sel;
   logic            mem_read;
   logic            mem_write;
   logic            busy;
   logic            halted;

   // Sequencer side
   modport master (
      input  start, instr, z_flag,
      output alu_op, Wen, INC, ac_clr, bus_sel, reg_wen, ir_wen, pc_inc,
             pc_load, ar_wen, addr_sel, mem_read, mem_write, busy, halted
   );

   // Datapath side
   modport slave (
      output start, instr, z_flag,
      input  alu_op, Wen, INC, ac_clr, bus_sel, reg_wen, ir_wen, pc_inc,
             pc_load, ar_wen, addr_sel, mem_read, mem_write, busy, halted
   );
endinterface

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute Moore sequencer driving the AC, register file, PC, AR and memory strobes.
// Latency: start->first ir_wen 3 cycles; ALU ops 5, LOAD 7+2*(MEM_LAT-1)... per state walk; reads wait MEM_LAT cycles.
// Backpressure: none; memory is fixed-latency, start is only sampled in IDLE.
module ctrl_sequencer #(
   parameter int NREG    = 8,
   parameter int MEM_LAT = 1
) (
   input logic              Clk,
   input logic              RST,
   ctrl_sequencer_if.master bus
);

   localparam int              CW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0]   WAIT_INIT = CW'(MEM_LAT - 1);
   localparam logic [3:0]      SEL_MEM   = 4'hD;
   localparam logic [3:0]      SEL_AC    = 4'hF;
   localparam logic [NREG-1:0] ONE_HOT0  = {{(NREG-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      IDLE, F_AR, F_RD, F_IR, DECODE, EXEC, M_AR, M_RD, M_WB, M_WR, HALT
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [2:0]      alu_op_q, alu_op_d;
   logic            wen_q, wen_d, inc_q, inc_d, ac_clr_q, ac_clr_d;
   logic [3:0]      bus_sel_q, bus_sel_d;
   logic [NREG-1:0] reg_wen_q, reg_wen_d;
   logic            ir_wen_q, ir_wen_d, pc_inc_q, pc_inc_d, jpz_q, jpz_d;
   logic            ar_wen_q, ar_wen_d, addr_sel_q, addr_sel_d;
   logic            mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic            busy_q, busy_d, halted_q, halted_d;

   logic [3:0]      op, rr;
   logic            r_ok;

   assign op   = bus.instr[7:4];
   assign rr   = bus.instr[3:0];
   // Operand codes beyond the register file turn register-using opcodes into NOPs
   assign r_ok = ({28'd0, rr} < 32'(NREG));

   // Next state and memory-wait down-counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE:   if (bus.start) state_d = F_AR;
         F_AR:   begin state_d = F_RD; cnt_d = WAIT_INIT; end
         F_RD:   if (cnt_q == '0) state_d = F_IR; else cnt_d = cnt_q - 1'b1;
         F_IR:   state_d = DECODE;
         DECODE: begin
            unique case (op)
               4'hA, 4'hB: state_d = r_ok ? M_AR : F_AR;
               4'hF:       state_d = HALT;
               default:    state_d = EXEC;
            endcase
         end
         EXEC:   state_d = F_AR;
         M_AR:   begin
            if (op == 4'hA) begin state_d = M_RD; cnt_d = WAIT_INIT; end
            else state_d = M_WR;
         end
         M_RD:   if (cnt_q == '0) state_d = M_WB; else cnt_d = cnt_q - 1'b1;
         M_WB:   state_d = F_AR;
         M_WR:   state_d = F_AR;
         HALT:   state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // Strobes for the state being entered, so every output leaves a flop
   always_comb begin
      alu_op_d    = 3'b000;
      wen_d       = 1'b0;
      inc_d       = 1'b0;
      ac_clr_d    = 1'b0;
      bus_sel_d   = 4'h0;
      reg_wen_d   = '0;
      ir_wen_d    = 1'b0;
      pc_inc_d    = 1'b0;
      jpz_d       = 1'b0;
      ar_wen_d    = 1'b0;
      addr_sel_d  = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      busy_d      = (state_d != IDLE) && (state_d != HALT);
      halted_d    = (state_d == HALT);
      unique case (state_d)
         F_AR:   ar_wen_d = 1'b1;
         F_RD:   mem_read_d = 1'b1;
         F_IR:   begin bus_sel_d = SEL_MEM; ir_wen_d = 1'b1; pc_inc_d = 1'b1; end
         EXEC:   begin
            unique case (op)
               4'h1: if (r_ok) begin bus_sel_d = rr; wen_d = 1'b1; end
               4'h2: if (r_ok) begin bus_sel_d = SEL_AC; reg_wen_d = ONE_HOT0 << rr; end
               4'h3, 4'h4, 4'h5, 4'h6:
                     if (r_ok) begin bus_sel_d = rr; alu_op_d = 3'(op - 4'd2); wen_d = 1'b1; end
               4'h7: inc_d = 1'b1;
               4'h8: ac_clr_d = 1'b1;
               4'h9: if (r_ok) begin bus_sel_d = rr; jpz_d = 1'b1; end
               default: ;
            endcase
         end
         M_AR:   begin bus_sel_d = rr; addr_sel_d = 1'b1; ar_wen_d = 1'b1; end
         M_RD:   mem_read_d = 1'b1;
         M_WB:   begin bus_sel_d = SEL_MEM; wen_d = 1'b1; end
         M_WR:   begin bus_sel_d = SEL_AC; mem_write_d = 1'b1; end
         default: ;
      endcase
   end

   // State, counter and output registers; reset clears everything at once
   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         alu_op_q    <= 3'b000;
         wen_q       <= 1'b0;
         inc_q       <= 1'b0;
         ac_clr_q    <= 1'b0;
         bus_sel_q   <= 4'h0;
         reg_wen_q   <= '0;
         ir_wen_q    <= 1'b0;
         pc_inc_q    <= 1'b0;
         jpz_q       <= 1'b0;
         ar_wen_q    <= 1'b0;
         addr_sel_q  <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_op_q    <= alu_op_d;
         wen_q       <= wen_d;
         inc_q       <= inc_d;
         ac_clr_q    <= ac_clr_d;
         bus_sel_q   <= bus_sel_d;
         reg_wen_q   <= reg_wen_d;
         ir_wen_q    <= ir_wen_d;
         pc_inc_q    <= pc_inc_d;
         jpz_q       <= jpz_d;
         ar_wen_q    <= ar_wen_d;
         addr_sel_q  <= addr_sel_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
      end
   end

   assign bus.alu_op    = alu_op_q;
   assign bus.Wen       = wen_q;
   assign bus.INC       = inc_q;
   assign bus.ac_clr    = ac_clr_q;
   assign bus.bus_sel   = bus_sel_q;
   assign bus.reg_wen   = reg_wen_q;
   assign bus.ir_wen    = ir_wen_q;
   assign bus.pc_inc    = pc_inc_q;
   // JPZ branches on the zero flag as it stands during EXEC itself
   assign bus.pc_load   = jpz_q & bus.z_flag;
   assign bus.ar_wen    = ar_wen_q;
   assign bus.addr_sel  = addr_sel_q;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.busy      = busy_q;
   assign bus.halted    = halted_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: one instance with MEM_LAT=1, one with MEM_LAT=3.
// Latency: each scenario walks the state sequence cycle by cycle against hand-built vectors.
// Backpressure: n/a; stimulus is applied #1 after each rising edge.
module tb_ctrl_sequencer;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       wen;
      logic       inc;
      logic       clr;
      logic [3:0] bus_sel;
      logic [7:0] reg_wen;
      logic       ir_wen;
      logic       pc_inc;
      logic       pc_load;
      logic       ar_wen;
      logic       addr_sel;
      logic       mem_read;
      logic       mem_write;
      logic       busy;
      logic       halted;
   } outs_t;

   logic Clk;
   logic RST;
   int   tests;
   int   failed;

   outs_t O_IDLE, O_FAR, O_FRD, O_FIR, O_DEC, O_HALT;

   ctrl_sequencer_if #(.NREG(8)) if1 ();
   ctrl_sequencer_if #(.NREG(8)) if3 ();

   ctrl_sequencer #(.NREG(8), .MEM_LAT(1)) dut1 (.Clk(Clk), .RST(RST), .bus(if1));
   ctrl_sequencer #(.NREG(8), .MEM_LAT(3)) dut3 (.Clk(Clk), .RST(RST), .bus(if3));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic outs_t sample1();
      outs_t o;
      o = '{if1.alu_op, if1.Wen, if1.INC, if1.ac_clr, if1.bus_sel, if1.reg_wen, if1.ir_wen,
            if1.pc_inc, if1.pc_load, if1.ar_wen, if1.addr_sel, if1.mem_read, if1.mem_write,
            if1.busy, if1.halted};
      return o;
   endfunction

   function automatic outs_t sample3();
      outs_t o;
      o = '{if3.alu_op, if3.Wen, if3.INC, if3.ac_clr, if3.bus_sel, if3.reg_wen, if3.ir_wen,
            if3.pc_inc, if3.pc_load, if3.ar_wen, if3.addr_sel, if3.mem_read, if3.mem_write,
            if3.busy, if3.halted};
      return o;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b0;
      #1;
      RST = 1'b1;
      step();
   endtask

   task automatic pulse_start1(input logic [7:0] ins);
      if1.instr = ins;
      if1.start = 1'b1;
      step();
      if1.start = 1'b0;
   endtask

   task automatic pulse_start3(input logic [7:0] ins);
      if3.instr = ins;
      if3.start = 1'b1;
      step();
      if3.start = 1'b0;
   endtask

   task automatic test_reset();
      outs_t got;
      #3;
      got = sample1();
      tests++;
      if (got !== O_IDLE) begin failed++; $display("FAIL reset_async1: got %h expected %h", got, O_IDLE); end
      got = sample3();
      tests++;
      if (got !== O_IDLE) begin failed++; $display("FAIL reset_async3: got %h expected %h", got, O_IDLE); end
      step();
      RST = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         got = sample1();
         tests++;
         if (got !== O_IDLE) begin failed++; $display("FAIL reset_idle cycle %0d: got %h expected %h", i, got, O_IDLE); end
      end
   endtask

   task automatic test_add();
      outs_t q[7];
      outs_t e, got;
      do_reset();
      e = O_DEC; e.bus_sel = 4'd3; e.alu_op = 3'b001; e.wen = 1'b1;
      q = '{O_FAR, O_FRD, O_FIR, O_DEC, e, O_FAR, O_FRD};
      pulse_start1(8'h33);
      foreach (q[i]) begin
         if (i != 0) step();
         got = sample1();
         tests++;
         if (got !== q[i]) begin failed++; $display("FAIL add_33 step %0d: got %h expected %h", i, got, q[i]); end
      end
   endtask

   task automatic test_jpz();
      outs_t q[10];
      outs_t e1, e0, got;
      do_reset();
      e1 = O_DEC; e1.bus_sel = 4'd2; e1.pc_load = 1'b1;
      e0 = O_DEC; e0.bus_sel = 4'd2;
      q = '{O_FAR, O_FRD, O_FIR, O_DEC, e1, O_FAR, O_FRD, O_FIR, O_DEC, e0};
      if1.z_flag = 1'b1;
      pulse_start1(8'h92);
      foreach (q[i]) begin
         if (i != 0) step();
         got = sample1();
         tests++;
         if (got !== q[i]) begin failed++; $display("FAIL jpz_92 step %0d: got %h expected %h", i, got, q[i]); end
         if (i == 5) if1.z_flag = 1'b0;
      end
   endtask

   task automatic test_load_lat3();
      outs_t q[12];
      outs_t ear, ewb, got;
      do_reset();
      ear = O_DEC; ear.bus_sel = 4'd5; ear.addr_sel = 1'b1; ear.ar_wen = 1'b1;
      ewb = O_DEC; ewb.bus_sel = 4'hD; ewb.wen = 1'b1;
      q = '{O_FAR, O_FRD, O_FRD, O_FRD, O_FIR, O_DEC, ear, O_FRD, O_FRD, O_FRD, ewb, O_FAR};
      pulse_start3(8'hA5);
      foreach (q[i]) begin
         if (i != 0) step();
         got = sample3();
         tests++;
         if (got !== q[i]) begin failed++; $display("FAIL load_a5_lat3 step %0d: got %h expected %h", i, got, q[i]); end
      end
   endtask

   task automatic test_reset_mid_read();
      outs_t q[3];
      outs_t got;
      do_reset();
      q = '{O_FAR, O_FRD, O_FRD};
      pulse_start3(8'h33);
      foreach (q[i]) begin
         if (i != 0) step();
         got = sample3();
         tests++;
         if (got !== q[i]) begin failed++; $display("FAIL midrd_pre step %0d: got %h expected %h", i, got, q[i]); end
      end
      RST = 1'b0;
      #1;
      got = sample3();
      tests++;
      if (got !== O_IDLE) begin failed++; $display("FAIL midrd_async: got %h expected %h", got, O_IDLE); end
      #1;
      RST = 1'b1;
      step();
      got = sample3();
      tests++;
      if (got !== O_IDLE) begin failed++; $display("FAIL midrd_idle: got %h expected %h", got, O_IDLE); end
      pulse_start3(8'h33);
      got = sample3();
      tests++;
      if (got !== O_FAR) begin failed++; $display("FAIL midrd_restart: got %h expected %h", got, O_FAR); end
   endtask

   task automatic test_operands();
      outs_t q6[6];
      outs_t q5[5];
      outs_t q7[7];
      outs_t e, emar, emwr, got;
      // MVR to an out-of-range register: EXEC with no strobes
      do_reset();
      q6 = '{O_FAR, O_FRD, O_FIR, O_DEC, O_DEC, O_FAR};
      pulse_start1(8'h2C);
      foreach (q6[i]) begin
         if (i != 0) step();
         got = sample1();
         tests++;
         if (got !== q6[i]) begin failed++; $display("FAIL mvr_2c step %0d: got %h expected %h", i, got, q6[i]); end
      end
      // MVR to r1: AC onto the bus, reg_wen one-hot bit 1
      do_reset();
      e = O_DEC; e.bus_sel = 4'hF; e.reg_wen = 8'h02;
      q6 = '{O_FAR, O_FRD, O_FIR, O_DEC, e, O_FAR};
      pulse_start1(8'h21);
      foreach (q6[i]) begin
         if (i != 0) step();
         got = sample1();
         tests++;
         if (got !== q6[i]) begin failed++; $display("FAIL mvr_21 step %0d: got %h expected %h", i, got, q6[i]); end
      end
      // LOAD with invalid operand goes straight back to fetch
      do_reset();
      q5 = '{O_FAR, O_FRD, O_FIR, O_DEC, O_FAR};
      pulse_start1(8'hA9);
      foreach (q5[i]) begin
         if (i != 0) step();
         got = sample1();
         tests++;
         if (got !== q5[i]) begin failed++; $display("FAIL load_a9 step %0d: got %h expected %h", i, got, q5[i]); end
      end
      // STORE r1
      do_reset();
      emar = O_DEC; emar.bus_sel = 4'd1; emar.addr_sel = 1'b1; emar.ar_wen = 1'b1;
      emwr = O_DEC; emwr.bus_sel = 4'hF; emwr.mem_write = 1'b1;
      q7 = '{O_FAR, O_FRD, O_FIR, O_DEC, emar, emwr, O_FAR};
      pulse_start1(8'hB1);
      foreach (q7[i]) begin
         if (i != 0) step();
         got = sample1();
         tests++;
         if (got !== q7[i]) begin failed++; $display("FAIL store_b1 step %0d: got %h expected %h", i, got, q7[i]); end
      end
   endtask

   task automatic test_back_to_back();
      outs_t q[15];
      outs_t ea, ei, ec, got;
      do_reset();
      ea = O_DEC; ea.bus_sel = 4'd4; ea.alu_op = 3'b100; ea.wen = 1'b1;
      ei = O_DEC; ei.inc = 1'b1;
      ec = O_DEC; ec.clr = 1'b1;
      q = '{O_FAR, O_FRD, O_FIR, O_DEC, ea,
            O_FAR, O_FRD, O_FIR, O_DEC, ei,
            O_FAR, O_FRD, O_FIR, O_DEC, ec};
      pulse_start1(8'h64);
      foreach (q[i]) begin
         if (i != 0) step();
         got = sample1();
         tests++;
         if (got !== q[i]) begin failed++; $display("FAIL b2b step %0d: got %h expected %h", i, got, q[i]); end
         if (i == 4) if1.instr = 8'h70;
         if (i == 9) if1.instr = 8'h80;
      end
   endtask

   task automatic test_halt();
      outs_t q[9];
      outs_t got;
      do_reset();
      q = '{O_FAR, O_FRD, O_FIR, O_DEC, O_HALT, O_HALT, O_HALT, O_HALT, O_HALT};
      pulse_start1(8'hF0);
      foreach (q[i]) begin
         if (i != 0) step();
         got = sample1();
         tests++;
         if (got !== q[i]) begin failed++; $display("FAIL halt_f0 step %0d: got %h expected %h", i, got, q[i]); end
         if (i == 4) if1.start = 1'b1;
         if (i == 6) if1.start = 1'b0;
      end
      do_reset();
      got = sample1();
      tests++;
      if (got !== O_IDLE) begin failed++; $display("FAIL halt_exit_reset: got %h expected %h", got, O_IDLE); end
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      RST    = 1'b0;
      if1.start = 1'b0; if1.instr = 8'h00; if1.z_flag = 1'b0;
      if3.start = 1'b0; if3.instr = 8'h00; if3.z_flag = 1'b0;

      O_IDLE = '0;
      O_FAR  = '0; O_FAR.busy = 1'b1; O_FAR.ar_wen = 1'b1;
      O_FRD  = '0; O_FRD.busy = 1'b1; O_FRD.mem_read = 1'b1;
      O_FIR  = '0; O_FIR.busy = 1'b1; O_FIR.bus_sel = 4'hD; O_FIR.ir_wen = 1'b1; O_FIR.pc_inc = 1'b1;
      O_DEC  = '0; O_DEC.busy = 1'b1;
      O_HALT = '0; O_HALT.halted = 1'b1;

      test_reset();
      test_add();
      test_jpz();
      test_load_lat3();
      test_reset_mid_read();
      test_operands();
      test_back_to_back();
      test_halt();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
